// File: rtl/dot_matrix_pkg.sv
// Shared constants for the 8x8 bicolour dot-matrix decimal counter.
// Latency: n/a (constants and pure helper functions only).
// Backpressure: n/a.
//
// Contents: digit font, count limits, default timing parameters, idle row
// pattern and small helpers shared by the font ROM and the counter top.
package dot_matrix_pkg;

  // Highest digit displayed; the count wraps to 0 after this value.
  localparam int DIGIT_MAX = 9;

  // Digits 0..GREEN_MAX are drawn in green, the rest in red.
  localparam int GREEN_MAX = 4;

  // Default timing: clock cycles per count step and per scanned row.
  localparam int TICK_CYCLES_DEF = 1000;
  localparam int SCAN_DIV_DEF    = 4;

  // Row lines are active-low; all-ones means no row selected (blank).
  localparam logic [7:0] ROW_IDLE = 8'hFF;

  typedef logic [7:0] glyph_row_t;

  // FONT[digit][row]: row 0 is the top row, bit 7 is the leftmost column.
  localparam glyph_row_t FONT [0:9][0:7] = '{
    '{8'h3C, 8'h66, 8'h6E, 8'h76, 8'h66, 8'h66, 8'h3C, 8'h00},  // 0
    '{8'h18, 8'h38, 8'h18, 8'h18, 8'h18, 8'h18, 8'h7E, 8'h00},  // 1
    '{8'h3C, 8'h66, 8'h06, 8'h0C, 8'h30, 8'h60, 8'h7E, 8'h00},  // 2
    '{8'h3C, 8'h66, 8'h06, 8'h1C, 8'h06, 8'h66, 8'h3C, 8'h00},  // 3
    '{8'h0C, 8'h1C, 8'h3C, 8'h6C, 8'h7E, 8'h0C, 8'h0C, 8'h00},  // 4
    '{8'h7E, 8'h60, 8'h7C, 8'h06, 8'h06, 8'h66, 8'h3C, 8'h00},  // 5
    '{8'h1C, 8'h30, 8'h60, 8'h7C, 8'h66, 8'h66, 8'h3C, 8'h00},  // 6
    '{8'h7E, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h30, 8'h30, 8'h00},  // 7
    '{8'h3C, 8'h66, 8'h66, 8'h3C, 8'h66, 8'h66, 8'h3C, 8'h00},  // 8
    '{8'h3C, 8'h66, 8'h66, 8'h3E, 8'h06, 8'h0C, 8'h38, 8'h00}   // 9
  };

  // Active-low one-hot row select for a row index.
  function automatic logic [7:0] row_select(input logic [2:0] ridx);
    return ~(8'h01 << ridx);
  endfunction

  // True when a digit is drawn on the red LEDs rather than the green ones.
  function automatic logic digit_is_red(input logic [3:0] digit);
    return (digit > 4'(GREEN_MAX));
  endfunction

endpackage

// File: rtl/dot_matrix_font_rom.sv
// Font ROM: returns one 8-pixel row of a decimal digit glyph.
// Latency: combinational (zero cycles).
// Backpressure: none; output follows the inputs continuously.
//
// Ports:
//   digit [3:0] : digit to draw; values above 9 yield a blank row.
//   ridx  [2:0] : glyph row, 0 = top.
//   glyph [7:0] : pixel row, bit 7 = leftmost column, 1 = lit.
module dot_matrix_font_rom
  import dot_matrix_pkg::*;
(
  input  logic [3:0] digit,
  input  logic [2:0] ridx,
  output logic [7:0] glyph
);

  always_comb begin
    glyph = 8'h00;
    // Guard keeps out-of-range digits from indexing past the font table.
    if (digit <= 4'(DIGIT_MAX)) begin
      glyph = FONT[digit][ridx];
    end
  end

endmodule

// File: rtl/dot_matrix_counter.sv
// Decimal 0-9 up-counter drawn on an 8x8 green/red dot matrix by row scanning.
// Latency: outputs are registered, one cycle behind the internal counters.
// Backpressure: none; free-running display leaf with no flow control.
//
// Ports:
//   clk        : system clock, all state on the rising edge.
//   rst        : asynchronous active-low reset; blanks the display at once.
//   row  [7:0] : active-low one-hot row select, row[0] = top row.
//   colg [7:0] : green column data, active-high, colg[7] = leftmost.
//   colr [7:0] : red column data, active-high, same bit order.
module dot_matrix_counter
  import dot_matrix_pkg::*;
#(
  parameter int TICK_CYCLES = TICK_CYCLES_DEF,  // cycles per count step, >= 2
  parameter int SCAN_DIV    = SCAN_DIV_DEF      // cycles per scanned row, >= 1
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] row,
  output logic [7:0] colg,
  output logic [7:0] colr
);

  // Counter widths; a one-cycle scan divider still needs a 1-bit register.
  localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CYCLES - 1);
  localparam logic [SW-1:0] SDIV_LAST  = SW'(SCAN_DIV - 1);

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [PW-1:0] presc, presc_nxt;
  logic [3:0]    digit, digit_nxt;
  logic [SW-1:0] sdiv,  sdiv_nxt;
  logic [2:0]    ridx,  ridx_nxt;

  logic          tick;       // count step happens on this edge
  logic          row_adv;    // scan moves to the next row on this edge

  logic [7:0]    glyph;
  logic [7:0]    row_nxt;
  logic [7:0]    colg_nxt;
  logic [7:0]    colr_nxt;

  // ---------------------------------------------------------------------
  // Prescaler and digit counter
  // ---------------------------------------------------------------------
  assign tick = (presc == PRESC_LAST);

  always_comb begin
    presc_nxt = presc + PW'(1);
    digit_nxt = digit;
    if (tick) begin
      presc_nxt = '0;
      // ">=" also pulls any stray 10..15 value back to 0 on the next step.
      if (digit >= 4'(DIGIT_MAX)) begin
        digit_nxt = 4'd0;
      end else begin
        digit_nxt = digit + 4'd1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Row scan counter
  // ---------------------------------------------------------------------
  assign row_adv = (sdiv == SDIV_LAST);

  always_comb begin
    sdiv_nxt = sdiv + SW'(1);
    ridx_nxt = ridx;
    if (row_adv) begin
      sdiv_nxt = '0;
      ridx_nxt = ridx + 3'd1;   // natural 3-bit wrap 7 -> 0
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc <= '0;
      digit <= 4'd0;
      sdiv  <= '0;
      ridx  <= 3'd0;
    end else begin
      presc <= presc_nxt;
      digit <= digit_nxt;
      sdiv  <= sdiv_nxt;
      ridx  <= ridx_nxt;
    end
  end

  // ---------------------------------------------------------------------
  // Glyph lookup and output registers
  // ---------------------------------------------------------------------
  dot_matrix_font_rom u_font_rom (
    .digit (digit),
    .ridx  (ridx),
    .glyph (glyph)
  );

  // The colour split is taken from the current digit, so a count step lands
  // mid-frame on whichever row is being scanned; there is no frame sync.
  always_comb begin
    row_nxt  = row_select(ridx);
    colg_nxt = 8'h00;
    colr_nxt = 8'h00;
    if (digit_is_red(digit)) begin
      colr_nxt = glyph;
    end else begin
      colg_nxt = glyph;
    end
  end

  // Reset blanks the matrix asynchronously: no row driven, no column lit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row  <= ROW_IDLE;
      colg <= 8'h00;
      colr <= 8'h00;
    end else begin
      row  <= row_nxt;
      colg <= colg_nxt;
      colr <= colr_nxt;
    end
  end

endmodule

// File: tb/tb_dot_matrix_counter.sv
`timescale 1ns/1ps
// Testbench for dot_matrix_counter: scoreboarded per-cycle check of the
// scanned display against a closed-form model (digit and row derived from
// the number of clock edges since reset release), plus reset checks.
module tb_dot_matrix_counter;

  localparam int TICK = 1000;
  localparam int SCAN = 4;

  // Independent copy of the glyphs, one 64-bit word per digit, row 0 in the
  // most significant byte.
  localparam logic [63:0] GLYPHS [10] = '{
    64'h3C666E7666663C00,
    64'h1838181818187E00,
    64'h3C66060C30607E00,
    64'h3C66061C06663C00,
    64'h0C1C3C6C7E0C0C00,
    64'h7E607C0606663C00,
    64'h1C30607C66663C00,
    64'h7E060C1830303000,
    64'h3C66663C66663C00,
    64'h3C66663E060C3800
  };

  typedef struct {
    logic [7:0] row;
    logic [7:0] colg;
    logic [7:0] colr;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [7:0] row;
  logic [7:0] colg;
  logic [7:0] colr;

  int   checks;
  int   passes;
  int   edges;     // rising edges since the last reset release
  exp_t sb[$];

  dot_matrix_counter #(
    .TICK_CYCLES (TICK),
    .SCAN_DIV    (SCAN)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .row  (row),
    .colg (colg),
    .colr (colr)
  );

  initial clk = 1'b0;
  always #1 clk = ~clk;   // 2 ns period (500 MHz)

  // Expected outputs right after edge n (n >= 1) since release: they show the
  // state that existed before that edge, i.e. after n-1 edges.
  function automatic exp_t model(input int n);
    exp_t        e;
    int          d;
    int          r;
    logic [63:0] w;
    logic [7:0]  g;
    d = ((n - 1) / TICK) % 10;
    r = ((n - 1) / SCAN) % 8;
    w = GLYPHS[d];
    g = w[63 - 8*r -: 8];
    e.row  = ~(8'h01 << r);
    e.colg = (d <= 4) ? g : 8'h00;
    e.colr = (d <= 4) ? 8'h00 : g;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) passes++;
    else $error("FAIL %s observed=%h expected=%h (edge %0d)", tag, obs, expv, edges);
  endtask

  task automatic chk_blank(input string tag);
    chk({tag, "_row"},  row,  8'hFF);
    chk({tag, "_colg"}, colg, 8'h00);
    chk({tag, "_colr"}, colr, 8'h00);
  endtask

  // Run n clock cycles; each edge pushes its expectation, which is popped and
  // compared half a period later together with the display invariants.
  task automatic run_cycles(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      edges++;
      sb.push_back(model(edges));
      #0.5;
      e = sb.pop_front();
      chk("row",  row,  e.row);
      chk("colg", colg, e.colg);
      chk("colr", colr, e.colr);
      chk("one_row_low", 8'($countones(~row)), 8'd1);
      chk("colour_overlap", colg & colr, 8'h00);
    end
  endtask

  initial begin
    checks = 0;
    passes = 0;
    edges  = 0;
    rst    = 1'b0;

    // Held in reset: display blank on every cycle.
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #0.5;
      chk_blank("reset_hold");
    end

    // Release away from the active edge; the next rising edge is edge 1.
    @(negedge clk);
    rst   = 1'b1;
    edges = 0;

    // First frame, count steps 0->5 and into digit 6.
    run_cycles(6010);

    // Asynchronous reset mid-cycle: blank before any further clock edge.
    #0.2;
    rst = 1'b0;
    #0.1;
    chk_blank("async_reset");
    chk("sb_empty", 8'(sb.size()), 8'd0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #0.5;
      chk_blank("reset_hold2");
    end

    // Restart from 0 with a full prescale period; run through a full digit
    // wrap 9 -> 0 and past the following step.
    @(negedge clk);
    rst   = 1'b1;
    edges = 0;
    run_cycles(11100);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/dot_matrix_counter.md
Name: dot_matrix_counter

Overview:
- Decimal up-counter (0–9) shown on an 8x8 bicolour (green/red) LED dot matrix.
- Drives row-scan and column-data lines directly.
- Top-level display leaf, clocked from the system clock; no other inputs.
- Digit advances at a fixed prescaled rate. The matrix is refreshed by time-multiplexed row scanning.

Parameters:
- TICK_CYCLES, 1000: clock cycles per count step (2 µs at 500 MHz bench clock); must be ≥2.
- SCAN_DIV, 4: clock cycles each row stays selected; must be ≥1.

Ports:
- clk, input, 1: system clock; all state on the rising edge.
- rst, input, 1: reset, asynchronous, active-low (rst=0 resets immediately; release is sampled on clk).
- row, output, 8: row select, active-low one-hot; row[i]=0 selects row i (row 0 = top).
- colg, output, 8: green column data, active-high; colg[7] = leftmost column.
- colr, output, 8: red column data, active-high; same bit order.

Behaviour:
- State registers:
  - presc: 0..TICK_CYCLES-1.
  - digit: 4 bits, 0..9.
  - sdiv: 0..SCAN_DIV-1.
  - ridx: 3 bits, 0..7.
- Reset (rst=0, async):
  - presc, digit, sdiv and ridx all clear to 0.
  - Outputs blank: row=8'hFF, colg=8'h00, colr=8'h00.
  - Holds while rst=0.
- Prescaler:
  - presc increments each cycle.
  - At TICK_CYCLES-1 it wraps to 0 and digit increments in the same edge.
  - digit 9 wraps to 0. Values 10–15 are unreachable; if reached, they go to 0 on the next tick.
- Scan:
  - sdiv increments each cycle.
  - At SCAN_DIV-1 it wraps to 0 and ridx increments; ridx 7 wraps to 0.
- Output registers, updated every edge from the current state (one-cycle latency):
  - row <= ~(8'b1 << ridx).
  - If digit ≤ 4: colg <= FONT[digit][ridx], colr <= 0 (green).
  - If digit ≥ 5: colr <= FONT[digit][ridx], colg <= 0 (red).
- First edge after reset release: row=FE, colg=3C, colr=00.
- A digit change takes effect on the row currently being scanned, at the next edge. No frame synchronisation.
- Invariants outside reset:
  - Exactly one row bit is low.
  - colg & colr == 0.
- FONT rows (row0..row7, hex, bit7 = left):
  - 0: 3C 66 6E 76 66 66 3C 00
  - 1: 18 38 18 18 18 18 7E 00
  - 2: 3C 66 06 0C 30 60 7E 00
  - 3: 3C 66 06 1C 06 66 3C 00
  - 4: 0C 1C 3C 6C 7E 0C 0C 00
  - 5: 7E 60 7C 06 06 66 3C 00
  - 6: 1C 30 60 7C 66 66 3C 00
  - 7: 7E 06 0C 18 30 30 30 00
  - 8: 3C 66 66 3C 66 66 3C 00
  - 9: 3C 66 66 3E 06 0C 38 00
- Reset mid-operation:
  - Outputs blank immediately, asynchronously.
  - After release the count restarts from 0, with the full TICK_CYCLES before the first step.

Decomposition:
- Shared package dot_matrix_pkg:
  - FONT constant array [0:9][0:7] of 8-bit.
  - DIGIT_MAX=9.
  - Default TICK_CYCLES and SCAN_DIV.
  - ROW_IDLE=8'hFF.
- One sub-module, dot_matrix_font_rom: combinational; inputs digit[3:0] and ridx[2:0]; output glyph[7:0]; outputs 0 for digit>9.
- Prescaler, scan counter and output registers stay in the top.

Test Plan:
- Reset values: hold rst=0 for 2 cycles -> row=FF, colg=00, colr=00, asynchronously even mid-cycle.
- First frame: release rst; sample rows over 32 cycles -> row sequence FE,FD,FB,F7,EF,DF,BF,7F (4 cycles each); colg = digit-0 glyph rows 3C,66,6E,76,66,66,3C,00; colr=00.
- Count step: after TICK_CYCLES=1000 cycles from release -> glyph switches to digit 1 (row0 colg=18). At 5000 cycles -> digit 5: colg=00, colr row0=7E.
- Wrap: run 10000 cycles -> digit returns to 0; green, row0 colg=3C.
- Mid-run reset: pull rst low at ~6000 cycles (digit 6) for 2 cycles -> immediate blank; after release, digit 0 shown and next step 1000 cycles later.
- Invariant checker over the whole run -> exactly one zero in row, colg & colr == 0, digit never shown >9.
